csr_bus_arbiter: RTL and testbench
==================================

CSR_BUS_ARBITER -- requirements
Module: csr_bus_arbiter

Interface
REQ-001 SHALL have parameter IDLE_ADDR, default 12'h000, the address driven on bus_addr when no address phase is active; it SHALL match no CSR in the system.
REQ-002 SHALL have ports clk (in, 1, clock) and rstn (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-003 SHALL have, for each requester i in {0,1}:
- req_i: in, 1, request.
- rd_i: in, 1, read.
- mod_i: in, 3, modify.
- wdata_i: in, 32, write data.
- addr_i: in, 12, CSR address.
- gnt_i: out, 1, grant pulse.
- done_i: out, 1, completion pulse.
REQ-004 SHALL have shared outputs rdata (out, 32, response data) and hit (out, 1, some CSR responded), both valid only when a done_i is high.
REQ-005 SHALL have bus ports to the CSR peripherals:
- bus_read: out, 1.
- bus_modify: out, 3.
- bus_wdata: out, 32.
- bus_addr: out, 12.
- bus_rdata: in, 32.
- bus_valid: in, 1.

Function
REQ-006 SHALL run an FSM with states IDLE, ADDR, EXEC and RESP; transitions are IDLE->ADDR on any req_i, ADDR->EXEC, EXEC->RESP and RESP->IDLE, all unconditional except the first.
REQ-007 In IDLE with a request pending, SHALL select an owner and capture that requester's rd/mod/wdata/addr into registers at the clock edge.
REQ-008 SHALL assert gnt_owner for exactly the ADDR cycle; the requester may drop req and change its fields from the following cycle.
REQ-009 In ADDR, SHALL drive bus_addr with the captured address, drive bus_modify=000 and bus_read=0.
REQ-010 In EXEC, SHALL drive bus_modify, bus_wdata and bus_read with the captured values, and drive bus_addr=IDLE_ADDR.
REQ-011 In any state other than ADDR, bus_addr SHALL equal IDLE_ADDR; in any state other than EXEC, bus_modify SHALL be 000 and bus_read SHALL be 0.
REQ-012 In RESP, SHALL register bus_rdata into rdata and bus_valid into hit.
REQ-013 SHALL pulse done_owner for one cycle in the cycle after RESP, which is IDLE.
REQ-014 A new grant MAY be decided in that same IDLE cycle.
REQ-015 Fixed latency SHALL be: request seen in IDLE at cycle T -> gnt in T+1 -> done in T+4; throughput SHALL be one transaction per 4 cycles.
REQ-016 SHALL pulse done even when hit=0, in which case rdata=0; the requester treats hit=0 as an illegal CSR access.
REQ-017 On simultaneous requests, SHALL apply the arbitration policy in REQ-022/REQ-023; a requester whose req is low in IDLE SHALL never be granted.
REQ-018 SHALL never assert gnt_0 and gnt_1 together, and SHALL never assert done_0 and done_1 together.
REQ-019 A requester holding req continuously SHALL receive back-to-back transactions, with gnt following each done by 1 cycle.

Reset
REQ-020 rstn low SHALL force, immediately and asynchronously:
- state=IDLE;
- gnt_*=0, done_*=0;
- rdata=0, hit=0;
- bus_read=0, bus_modify=000, bus_wdata=0, bus_addr=IDLE_ADDR;
- round-robin pointer = "last granted 1".
REQ-021 Reset asserted during EXEC SHALL remove bus_modify before the next clock edge, so no write is committed; the interrupted requester receives no done.

Configuration
REQ-022 With macro CSR_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last; the pointer updates on each grant.
REQ-023 Without CSR_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win simultaneous requests and the pointer SHALL not exist.

Structure
REQ-024 Shared package csr_arb_pkg SHALL contain:
- the FSM state enum;
- the modify encodings MOD_NONE=000, MOD_WRITE=001, MOD_SET=010, MOD_CLEAR=011.
REQ-025 The grant decision SHALL be a sub-module csr_arb_pick: inputs req[1:0] and the last-grant pointer; output a one-hot pick.

Verification
REQ-026 Single read: req_0 with addr=F14, rd=1 and the bus model returning 0000_0005/valid -> gnt_0 at T+1, bus_addr=F14 at T+1, bus_read=1 at T+2, done_0 at T+4 with rdata=5 and hit=1.
REQ-027 Write: req_1 with addr=BC1, mod=001, wdata=A -> bus_modify=001 and bus_wdata=A only in EXEC; bus_addr=000 in EXEC.
REQ-028 Contention: req_0 and req_1 both held high from reset -> grant order 0,1,0,1 with round robin; 0,0,0 without it.
REQ-029 Unmapped address: addr=123 with the bus model returning valid=0 -> done with hit=0 and rdata=0.
REQ-030 Reset in EXEC: rstn low mid-cycle -> bus_modify=000 immediately; no done; after release, a fresh request completes normally.
REQ-031 Back-to-back: req_0 held high for 3 transactions -> done at T+4, T+8, T+12; gnt never overlaps done of the other requester.

Source files
------------

// File: rtl/csr_arb_pkg.sv
// csr_arb_pkg -- shared definitions for the CSR bus arbiter.
//   arb_state_t : transaction FSM states (IDLE -> ADDR -> EXEC -> RESP)
//   MOD_*       : encodings carried on mod_i / bus_modify
//   DATA_W      : CSR data width
//   ADDR_W      : CSR address width
package csr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic [2:0] MOD_NONE  = 3'b000;
  localparam logic [2:0] MOD_WRITE = 3'b001;
  localparam logic [2:0] MOD_SET   = 3'b010;
  localparam logic [2:0] MOD_CLEAR = 3'b011;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;

endpackage

// File: rtl/csr_arb_pick.sv
// csr_arb_pick -- grant decision for two requesters.
//   req  [1:0] : pending requests
//   last       : requester granted most recently (0 or 1)
//   pick [1:0] : one-hot winner, 00 when nobody requests
// On a tie the requester that was not granted last wins. Holding last at 1
// therefore gives requester 0 fixed priority.
module csr_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/csr_bus_arbiter.sv
// csr_bus_arbiter -- shares one CSR bus between two requesters.
//   Each transaction runs IDLE -> ADDR -> EXEC -> RESP -> IDLE:
//     ADDR : gnt_<owner> high, bus_addr = captured address
//     EXEC : bus_read / bus_modify / bus_wdata = captured command
//     RESP : bus_rdata / bus_valid registered into rdata / hit
//     IDLE : done_<owner> pulses; a new grant may be decided in the same cycle
// Ports:
//   clk, rstn (async, active-low)
//   req_i, rd_i, mod_i[2:0], wdata_i[31:0], addr_i[11:0] : requester i command
//   gnt_i, done_i                                        : requester i pulses
//   rdata[31:0], hit                                     : response, valid with done_i
//   bus_read, bus_modify[2:0], bus_wdata[31:0], bus_addr[11:0] : CSR bus drive
//   bus_rdata[31:0], bus_valid                           : CSR bus response
// Parameter IDLE_ADDR: address parked on bus_addr outside ADDR; must map no CSR.
// Build option CSR_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous
// requests; when undefined, requester 0 always wins a tie.
module csr_bus_arbiter
  import csr_arb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IDLE_ADDR = 12'h000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_0,
  input  logic              rd_0,
  input  logic [2:0]        mod_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [ADDR_W-1:0] addr_0,
  output logic              gnt_0,
  output logic              done_0,
  input  logic              req_1,
  input  logic              rd_1,
  input  logic [2:0]        mod_1,
  input  logic [DATA_W-1:0] wdata_1,
  input  logic [ADDR_W-1:0] addr_1,
  output logic              gnt_1,
  output logic              done_1,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic              bus_read,
  output logic [2:0]        bus_modify,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_valid
);

  arb_state_t        state, state_nxt;
  logic [1:0]        req_vec;
  logic [1:0]        pick;
  logic              last_gnt;
  logic              take;
  logic [1:0]        owner_r;
  logic              done_pend;
  logic              rd_r;
  logic [2:0]        mod_r;
  logic [DATA_W-1:0] wdata_r;
  logic [ADDR_W-1:0] addr_r;

  assign req_vec = {req_1, req_0};
  assign take    = (state == IDLE) && (req_vec != 2'b00);

`ifdef CSR_ARB_ROUND_ROBIN_EN
  logic last_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_r <= 1'b1;
    end else if (take) begin
      last_r <= pick[1];
    end
  end

  assign last_gnt = last_r;
`else
  // A permanent "last granted 1" makes the picker favour requester 0.
  assign last_gnt = 1'b1;
`endif

  csr_arb_pick u_pick (
    .req  (req_vec),
    .last (last_gnt),
    .pick (pick)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = take ? ADDR : IDLE;
      ADDR:    state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Owner, completion flag and response registers. Clearing done_pend on
  // reset is what denies a done to a transaction cut short by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_r   <= 2'b00;
      done_pend <= 1'b0;
      rdata     <= '0;
      hit       <= 1'b0;
    end else begin
      if (take) begin
        owner_r <= pick;
      end
      done_pend <= (state == RESP);
      if (state == RESP) begin
        hit   <= bus_valid;
        rdata <= bus_valid ? bus_rdata : '0;
      end
    end
  end

  // Command capture; requester may change its fields once granted.
  always_ff @(posedge clk) begin
    if (take) begin
      rd_r    <= pick[1] ? rd_1    : rd_0;
      mod_r   <= pick[1] ? mod_1   : mod_0;
      wdata_r <= pick[1] ? wdata_1 : wdata_0;
      addr_r  <= pick[1] ? addr_1  : addr_0;
    end
  end

  // Outputs decode from state only, so an async reset clears the bus at once.
  always_comb begin
    gnt_0      = 1'b0;
    gnt_1      = 1'b0;
    done_0     = done_pend & owner_r[0];
    done_1     = done_pend & owner_r[1];
    bus_addr   = IDLE_ADDR;
    bus_read   = 1'b0;
    bus_modify = MOD_NONE;
    bus_wdata  = '0;
    case (state)
      ADDR: begin
        gnt_0    = owner_r[0];
        gnt_1    = owner_r[1];
        bus_addr = addr_r;
      end
      EXEC: begin
        bus_read   = rd_r;
        bus_modify = mod_r;
        bus_wdata  = wdata_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// tb_csr_bus_arbiter -- self-checking bench for csr_bus_arbiter.
// Directed transactions from a vector table, hand-written contention,
// reset-in-EXEC and back-to-back sequences, then randomized traffic checked
// cycle by cycle against a transaction-schedule reference model.
`timescale 1ns/1ps
module tb_csr_bus_arbiter;
  import csr_arb_pkg::*;

  localparam logic [11:0] IDLE_A = 12'h000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_0 = 1'b0, rd_0 = 1'b0, req_1 = 1'b0, rd_1 = 1'b0;
  logic [2:0]  mod_0 = '0, mod_1 = '0;
  logic [31:0] wdata_0 = '0, wdata_1 = '0;
  logic [11:0] addr_0 = '0, addr_1 = '0;
  logic        gnt_0, gnt_1, done_0, done_1, hit, bus_read;
  logic [31:0] rdata, bus_wdata;
  logic [2:0]  bus_modify;
  logic [11:0] bus_addr;
  logic [31:0] bus_rdata = '0;
  logic        bus_valid = 1'b0;

  always #5 clk = ~clk;

  csr_bus_arbiter #(.IDLE_ADDR(IDLE_A)) dut (
    .clk(clk), .rstn(rstn),
    .req_0(req_0), .rd_0(rd_0), .mod_0(mod_0), .wdata_0(wdata_0), .addr_0(addr_0),
    .gnt_0(gnt_0), .done_0(done_0),
    .req_1(req_1), .rd_1(rd_1), .mod_1(mod_1), .wdata_1(wdata_1), .addr_1(addr_1),
    .gnt_1(gnt_1), .done_1(done_1),
    .rdata(rdata), .hit(hit),
    .bus_read(bus_read), .bus_modify(bus_modify), .bus_wdata(bus_wdata),
    .bus_addr(bus_addr), .bus_rdata(bus_rdata), .bus_valid(bus_valid)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        who;
    logic        rd;
    logic [2:0]  mod;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] brdata;
    logic        bvalid;
    logic [31:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  typedef struct {
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        rd;
    logic [2:0]  mod;
    logic [31:0] wd;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        hit;
  } exp_t;

  task automatic drive(input logic who, input logic rq, input logic rd,
                       input logic [2:0] md, input logic [31:0] wd, input logic [11:0] ad);
    if (who) begin
      req_1 = rq; rd_1 = rd; mod_1 = md; wdata_1 = wd; addr_1 = ad;
    end else begin
      req_0 = rq; rd_0 = rd; mod_0 = md; wdata_0 = wd; addr_0 = ad;
    end
  endtask

  task automatic scramble();
    req_0 = 1'b0; rd_0 = 1'($urandom); mod_0 = 3'($urandom); wdata_0 = $urandom; addr_0 = 12'($urandom);
    req_1 = 1'b0; rd_1 = 1'($urandom); mod_1 = 3'($urandom); wdata_1 = $urandom; addr_1 = 12'($urandom);
  endtask

  // Called at a falling edge with the arbiter idle; returns in the done cycle.
  task automatic run_txn(input vec_t v, input int idx);
    logic [1:0] oh;
    oh = v.who ? 2'b10 : 2'b01;
    scramble();
    drive(v.who, 1'b1, v.rd, v.mod, v.wdata, v.addr);
    @(negedge clk);
    chk($sformatf("v%0d_gnt", idx), {gnt_1, gnt_0, done_1, done_0}, {oh, 2'b00});
    chk($sformatf("v%0d_addr_phase", idx), {bus_addr, bus_read, bus_modify, bus_wdata},
        {v.addr, 1'b0, MOD_NONE, 32'h0});
    scramble();
    @(negedge clk);
    chk($sformatf("v%0d_exec_phase", idx), {gnt_1, gnt_0, bus_addr, bus_read, bus_modify, bus_wdata},
        {2'b00, IDLE_A, v.rd, v.mod, v.wdata});
    @(negedge clk);
    bus_rdata = v.brdata;
    bus_valid = v.bvalid;
    chk($sformatf("v%0d_resp_phase", idx), {done_1, done_0, bus_addr, bus_read, bus_modify},
        {2'b00, IDLE_A, 1'b0, MOD_NONE});
    @(negedge clk);
    bus_rdata = $urandom;
    bus_valid = 1'b0;
    chk($sformatf("v%0d_done", idx), {gnt_1, gnt_0, done_1, done_0}, {2'b00, oh});
    chk($sformatf("v%0d_rdata_hit", idx), {rdata, hit}, {v.exp_rdata, v.exp_hit});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    scramble();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    int   gq[$];
    int   dq[$];
    int   exp_order[4];
    int   n_done;
    exp_t ring[16];
    exp_t e;
    exp_t idle_e;
    int   free_at;
    int   resp_at;
    logic win;
    logic [1:0] oh;
`ifdef CSR_ARB_ROUND_ROBIN_EN
    logic m_last;
`endif

    vt[0] = '{who:1'b0, rd:1'b1, mod:MOD_NONE,  wdata:32'h0,        addr:12'hF14,
              brdata:32'h0000_0005, bvalid:1'b1, exp_rdata:32'h0000_0005, exp_hit:1'b1};
    vt[1] = '{who:1'b1, rd:1'b0, mod:MOD_WRITE, wdata:32'h0000_000A, addr:12'hBC1,
              brdata:32'h0,         bvalid:1'b1, exp_rdata:32'h0,         exp_hit:1'b1};
    vt[2] = '{who:1'b0, rd:1'b1, mod:MOD_NONE,  wdata:32'h0,        addr:12'h123,
              brdata:32'hDEAD_BEEF, bvalid:1'b0, exp_rdata:32'h0,         exp_hit:1'b0};
    vt[3] = '{who:1'b1, rd:1'b1, mod:MOD_SET,   wdata:32'h0000_0F00, addr:12'h7A0,
              brdata:32'h1234_5678, bvalid:1'b1, exp_rdata:32'h1234_5678, exp_hit:1'b1};

    // Reset values while rstn is held low
    #2;
    chk("reset_state", {gnt_1, gnt_0, done_1, done_0, rdata, hit, bus_read, bus_modify, bus_wdata, bus_addr},
        {4'b0000, 32'h0, 1'b0, 1'b0, MOD_NONE, 32'h0, IDLE_A});
    @(negedge clk);
    rstn = 1'b1;

    // Directed single transactions
    for (int i = 0; i < 4; i++) run_txn(vt[i], i);

    // Contention: both requesters held high from reset
    @(negedge clk);
    rstn = 1'b0;
    drive(1'b0, 1'b1, 1'b1, MOD_NONE, 32'h0, 12'h010);
    drive(1'b1, 1'b1, 1'b1, MOD_NONE, 32'h0, 12'h020);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 24 && gq.size() < 4; c++) begin
      @(negedge clk);
      if (gnt_0 && gnt_1) chk("cont_gnt_overlap", {gnt_1, gnt_0}, 2'b00);
      if (gnt_0) gq.push_back(0);
      if (gnt_1) gq.push_back(1);
    end
    scramble();
`ifdef CSR_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    chk("cont_grant_count", gq.size(), 4);
    for (int i = 0; i < gq.size() && i < 4; i++)
      chk($sformatf("cont_grant_%0d", i), gq[i], exp_order[i]);
    repeat (4) @(negedge clk);

    // Reset asserted in the middle of an EXEC cycle of a write
    drive(1'b0, 1'b1, 1'b0, MOD_WRITE, 32'h0000_0077, 12'h055);
    @(negedge clk);
    scramble();
    @(negedge clk);
    chk("rst_exec_before", bus_modify, MOD_WRITE);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_exec_bus_cleared", {bus_modify, bus_read, bus_wdata, bus_addr, gnt_1, gnt_0},
        {MOD_NONE, 1'b0, 32'h0, IDLE_A, 2'b00});
    @(negedge clk);
    rstn = 1'b1;
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_0 || done_1) n_done++;
    end
    chk("rst_exec_no_done", n_done, 0);
    run_txn(vt[0], 4);

    // Back-to-back: requester 0 holds req for three full transactions
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, MOD_NONE, 32'h0, 12'hF14);
    bus_rdata = 32'h5;
    bus_valid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (gnt_0) gq.push_back(c);
      if (done_0) dq.push_back(c);
      if (gnt_1 || done_1) chk("b2b_other_active", {gnt_1, done_1}, 2'b00);
      if (c == 9) req_0 = 1'b0;
    end
    gq = gq[4:$];
    chk("b2b_gnt_count", gq.size(), 3);
    chk("b2b_done_count", dq.size(), 3);
    for (int i = 0; i < 3 && i < gq.size(); i++) chk($sformatf("b2b_gnt_%0d", i), gq[i], 1 + 4 * i);
    for (int i = 0; i < 3 && i < dq.size(); i++) chk($sformatf("b2b_done_%0d", i), dq[i], 4 + 4 * i);
    bus_valid = 1'b0;

    // Randomized traffic against the schedule model
    do_reset();
    idle_e = '{gnt:2'b00, done:2'b00, rd:1'b0, mod:MOD_NONE, wd:32'h0, addr:IDLE_A, rdata:32'h0, hit:1'b0};
    for (int i = 0; i < 16; i++) ring[i] = idle_e;
    free_at = 0;
    resp_at = -1;
`ifdef CSR_ARB_ROUND_ROBIN_EN
    m_last = 1'b1;
`endif
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      e = ring[c % 16];
      chk("rnd_outputs",
          {gnt_1, gnt_0, done_1, done_0, bus_read, bus_modify, bus_wdata, bus_addr},
          {e.gnt, e.done, e.rd, e.mod, e.wd, e.addr});
      if (e.done != 2'b00) chk("rnd_response", {rdata, hit}, {e.rdata, e.hit});
      ring[c % 16] = idle_e;

      req_0 = ($urandom_range(0, 3) != 0); rd_0 = 1'($urandom); mod_0 = 3'($urandom);
      wdata_0 = $urandom; addr_0 = 12'($urandom);
      req_1 = ($urandom_range(0, 3) != 0); rd_1 = 1'($urandom); mod_1 = 3'($urandom);
      wdata_1 = $urandom; addr_1 = 12'($urandom);
      bus_rdata = $urandom;
      bus_valid = 1'($urandom);

      if (c == resp_at) begin
        ring[(c + 1) % 16].rdata = bus_valid ? bus_rdata : 32'h0;
        ring[(c + 1) % 16].hit   = bus_valid;
      end

      if (c >= free_at && (req_0 || req_1)) begin
        if (req_0 && req_1) begin
`ifdef CSR_ARB_ROUND_ROBIN_EN
          win = ~m_last;
`else
          win = 1'b0;
`endif
        end else begin
          win = req_1;
        end
`ifdef CSR_ARB_ROUND_ROBIN_EN
        m_last = win;
`endif
        oh = win ? 2'b10 : 2'b01;
        ring[(c + 1) % 16].gnt  = oh;
        ring[(c + 1) % 16].addr = win ? addr_1 : addr_0;
        ring[(c + 2) % 16].rd   = win ? rd_1 : rd_0;
        ring[(c + 2) % 16].mod  = win ? mod_1 : mod_0;
        ring[(c + 2) % 16].wd   = win ? wdata_1 : wdata_0;
        ring[(c + 4) % 16].done = oh;
        resp_at = c + 3;
        free_at = c + 4;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
